// File: rtl/mem_bridge_pkg.sv
// Shared types for the core-to-pipelined-memory request bridge.
//   state_t : bridge FSM states
//   err_t   : sticky error codes reported on the err output
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_RW      = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

endpackage

// File: rtl/bridge_watchdog.sv
// Transaction watchdog: counts cycles while enabled, cleared on demand.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : zero the count (takes priority over enable)
//   enable   : count this cycle
//   expired  : this enabled cycle is the TIMEOUT_CYCLES-th counted cycle
module bridge_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    // The count holds the number of earlier counted cycles, so equality with
    // LAST flags the final permitted cycle itself.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_req_bridge.sv
// Bridges a simple held-request core memory port onto a pipelined
// request/grant/rvalid memory port, one transaction at a time.
//   Core side  : mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
//                -> mem_resp (1-cycle pulse), mem_rdata
//   Memory side: pmem_req, pmem_we, pmem_addr (word aligned), pmem_wmask,
//                pmem_wdata -> pmem_gnt, pmem_rvalid, pmem_rdata
//   err        : sticky error (0 none, 1 read+write collision, 2 timeout)
module mem_req_bridge
    import mem_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        pmem_req,
    output logic        pmem_we,
    output logic [31:0] pmem_addr,
    output logic [3:0]  pmem_wmask,
    output logic [31:0] pmem_wdata,
    input  logic        pmem_gnt,
    input  logic        pmem_rvalid,
    input  logic [31:0] pmem_rdata,
    output logic [1:0]  err
);

    state_t      state, state_nxt;
    err_t        err_q, err_nxt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic [31:0] rdata_q;
    logic        load;
    logic        capture;
    logic        wd_clear;
    logic        wd_en;
    logic        wd_expired;

    bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_en),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            err_q     <= ERR_NONE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (load) begin
                lat_we    <= mem_write;
                lat_addr  <= mem_address;
                lat_be    <= mem_byte_enable;
                lat_wdata <= mem_wdata;
            end
            if (capture) begin
                rdata_q <= pmem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        load      = 1'b0;
        capture   = 1'b0;
        wd_clear  = (state == IDLE);
        wd_en     = (state == REQ) || (state == WAIT);

        unique case (state)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    load      = 1'b1;
                    state_nxt = REQ;
                end else if (mem_read && mem_write && (err_q == ERR_NONE)) begin
                    err_nxt = ERR_RW;
                end
            end
            // The watchdog wins over a grant or rvalid arriving on the final
            // permitted cycle, so a transaction never exceeds its budget.
            REQ: begin
                if (wd_expired) begin
                    state_nxt = IDLE;
                    if (err_q == ERR_NONE) err_nxt = ERR_TIMEOUT;
                end else if (pmem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wd_expired) begin
                    state_nxt = IDLE;
                    if (err_q == ERR_NONE) err_nxt = ERR_TIMEOUT;
                end else if (pmem_rvalid) begin
                    capture   = !lat_we;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        mem_resp   = (state == RESP);
        pmem_req   = (state == REQ);
        pmem_we    = lat_we;
        pmem_addr  = lat_addr & 32'hFFFF_FFFC;
        pmem_wmask = lat_we ? lat_be : 4'b0000;
        pmem_wdata = lat_wdata;
        mem_rdata  = rdata_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Self-checking bench for mem_req_bridge. Each transaction's expected
// outputs are scheduled per cycle from its grant/rvalid delays and the
// watchdog budget; one compare process checks the DUT every cycle.
module tb_mem_req_bridge;

    localparam int TO = 8;
    localparam int N  = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [3:0]  mem_byte_enable = '0;
    logic [31:0] mem_address = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        pmem_req;
    logic        pmem_we;
    logic [31:0] pmem_addr;
    logic [3:0]  pmem_wmask;
    logic [31:0] pmem_wdata;
    logic        pmem_gnt = 1'b0;
    logic        pmem_rvalid = 1'b0;
    logic [31:0] pmem_rdata = '0;
    logic [1:0]  err;

    mem_req_bridge #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .pmem_req       (pmem_req),
        .pmem_we        (pmem_we),
        .pmem_addr      (pmem_addr),
        .pmem_wmask     (pmem_wmask),
        .pmem_wdata     (pmem_wdata),
        .pmem_gnt       (pmem_gnt),
        .pmem_rvalid    (pmem_rvalid),
        .pmem_rdata     (pmem_rdata),
        .err            (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int dut_resp_cnt = 0;
    int model_err = 0;
    bit chk_en = 1'b0;

    // Expected-output schedule, indexed by cycle number.
    bit          e_req   [N];
    bit          e_we    [N];
    logic [31:0] e_addr  [N];
    logic [3:0]  e_mask  [N];
    logic [31:0] e_wdata [N];
    bit          e_resp  [N];
    bit          rd_upd  [N];
    logic [31:0] rd_val  [N];
    bit          err_upd [N];
    logic [1:0]  err_val [N];

    logic [31:0] run_rdata = '0;
    logic [1:0]  run_err = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=0x%08h required=0x%08h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            run_rdata = '0;
            run_err   = '0;
        end
        if (mem_resp === 1'b1) dut_resp_cnt++;
        if (chk_en && cyc < N) begin
            if (rd_upd[cyc])  run_rdata = rd_val[cyc];
            if (err_upd[cyc]) run_err   = err_val[cyc];
            chk("mem_resp",  32'(mem_resp),  32'(e_resp[cyc]));
            chk("pmem_req",  32'(pmem_req),  32'(e_req[cyc]));
            chk("mem_rdata", mem_rdata,      run_rdata);
            chk("err",       32'(err),       32'(run_err));
            if (e_req[cyc]) begin
                chk("pmem_we",    32'(pmem_we),    32'(e_we[cyc]));
                chk("pmem_addr",  pmem_addr,       e_addr[cyc]);
                chk("pmem_wmask", 32'(pmem_wmask), 32'(e_mask[cyc]));
                chk("pmem_wdata", pmem_wdata,      e_wdata[cyc]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "bench did not finish");
    end

    task automatic do_reset();
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_gnt = 1'b0;
        pmem_rvalid = 1'b0;
        #1;
        chk("rst_mem_resp",   32'(mem_resp),   32'h0);
        chk("rst_pmem_req",   32'(pmem_req),   32'h0);
        chk("rst_pmem_we",    32'(pmem_we),    32'h0);
        chk("rst_pmem_addr",  pmem_addr,       32'h0);
        chk("rst_pmem_wmask", 32'(pmem_wmask), 32'h0);
        chk("rst_pmem_wdata", pmem_wdata,      32'h0);
        chk("rst_mem_rdata",  mem_rdata,       32'h0);
        chk("rst_err",        32'(err),        32'h0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int k = cyc; k < N; k++) begin
            e_req[k] = 1'b0;
            e_resp[k] = 1'b0;
            rd_upd[k] = 1'b0;
            err_upd[k] = 1'b0;
        end
        model_err = 0;
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            mem_read = 1'b0;
            mem_write = 1'b0;
            mem_address = $urandom;
            pmem_gnt = ($urandom_range(0, 3) == 0);
            pmem_rvalid = ($urandom_range(0, 3) == 0);
            pmem_rdata = $urandom;
            @(negedge clk);
        end
        pmem_gnt = 1'b0;
        pmem_rvalid = 1'b0;
    endtask

    // One core transaction. g: cycles in REQ before the grant cycle,
    // r: cycles in WAIT before the rvalid cycle. The transaction completes
    // only if rvalid falls within the first TO-1 REQ+WAIT cycles; otherwise
    // the TO-th cycle aborts it. Starts and ends on a falling edge.
    task automatic txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int g, input int r,
                       input logic [31:0] rdv, input int gap, input bit pin,
                       input logic [31:0] pin_addr, input logic [3:0] pin_mask,
                       input int pin_reqcyc, input int pin_resp_j,
                       input logic [31:0] pin_rdata);
        int c, gi, vi, reqlast, last, reqcnt;
        bit done;
        c = cyc;
        if (c + 2 * TO + 8 >= N) begin
            $display("FAIL schedule_overflow cyc=%0d actual=%0d required<%0d", cyc, c, N);
            $fatal(1, "schedule overflow");
        end
        gi = g + 1;
        vi = g + r + 2;
        done = (vi < TO);
        reqlast = (gi < TO) ? gi : TO;
        last = done ? vi + 1 : TO;
        reqcnt = 0;
        for (int j = 1; j <= reqlast; j++) begin
            e_req[c+j]   = 1'b1;
            e_we[c+j]    = we;
            e_addr[c+j]  = addr & 32'hFFFF_FFFC;
            e_mask[c+j]  = we ? be : 4'b0000;
            e_wdata[c+j] = wd;
        end
        if (done) begin
            e_resp[c+vi+1] = 1'b1;
            if (!we) begin
                rd_upd[c+vi+1] = 1'b1;
                rd_val[c+vi+1] = rdv;
            end
        end else if (model_err == 0) begin
            err_upd[c+TO+1] = 1'b1;
            err_val[c+TO+1] = 2'd2;
            model_err = 2;
        end
        for (int j = 0; j <= last; j++) begin
            if (j == 0) begin
                mem_read = !we;
                mem_write = we;
                mem_address = addr;
                mem_byte_enable = be;
                mem_wdata = wd;
            end else begin
                mem_address = $urandom;
                mem_byte_enable = 4'($urandom);
                mem_wdata = $urandom;
                if (done && j == last) begin
                    mem_read = 1'b0;
                    mem_write = 1'b0;
                end
            end
            if (j == gi) pmem_gnt = 1'b1;
            else if (j > 0 && j < gi) pmem_gnt = 1'b0;
            else pmem_gnt = ($urandom_range(0, 3) == 0);
            if (j == vi) pmem_rvalid = 1'b1;
            else if (j > gi && j < vi) pmem_rvalid = 1'b0;
            else pmem_rvalid = ($urandom_range(0, 3) == 0);
            pmem_rdata = (j == vi) ? rdv : $urandom;
            if (pin) begin
                if (j == 1) begin
                    chk("pin_addr", pmem_addr, pin_addr);
                    chk("pin_mask", 32'(pmem_wmask), 32'(pin_mask));
                end
                if (pmem_req === 1'b1) reqcnt++;
                if (j == pin_resp_j) begin
                    chk("pin_resp", 32'(mem_resp), 32'h1);
                    chk("pin_rdata", mem_rdata, pin_rdata);
                end
            end
            @(negedge clk);
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_gnt = 1'b0;
        pmem_rvalid = 1'b0;
        if (pin) chk("pin_req_cycles", 32'(reqcnt), 32'(pin_reqcyc));
        idle_cycles(gap);
    endtask

    task automatic collide();
        int c;
        c = cyc;
        if (model_err == 0) begin
            err_upd[c+1] = 1'b1;
            err_val[c+1] = 2'd1;
            model_err = 1;
        end
        mem_read = 1'b1;
        mem_write = 1'b1;
        mem_address = $urandom;
        pmem_gnt = 1'($urandom_range(0, 1));
        pmem_rvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_gnt = 1'b0;
        pmem_rvalid = 1'b0;
    endtask

    task automatic random_txn();
        bit we;
        int g, r;
        we = 1'($urandom_range(0, 1));
        g = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
        r = int'($urandom_range(0, 3));
        txn(we, $urandom, 4'($urandom), $urandom, g, r, $urandom,
            int'($urandom_range(0, 2)), 1'b0, '0, '0, 0, -1, '0);
    endtask

    initial begin
        int s;

        do_reset();

        // Minimum-latency read, unaligned address.
        txn(1'b0, 32'h0000_1006, 4'hF, 32'h0, 0, 0, 32'hDEAD_BEEF, 1,
            1'b1, 32'h0000_1004, 4'b0000, 1, 3, 32'hDEAD_BEEF);

        // Write with a grant delayed five cycles; read data must not change.
        txn(1'b1, 32'h0000_2000, 4'b0011, 32'h1234_5678, 5, 0, 32'h0, 1,
            1'b1, 32'h0000_2000, 4'b0011, 6, 8, 32'hDEAD_BEEF);

        // Back-to-back read then write, each issued right after mem_resp.
        s = dut_resp_cnt;
        txn(1'b0, 32'h0000_0100, 4'hF, 32'h0, 1, 1, 32'hA5A5_0001, 0,
            1'b0, '0, '0, 0, -1, '0);
        txn(1'b1, 32'h0000_0104, 4'b1100, 32'hCAFE_F00D, 0, 2, 32'h0, 0,
            1'b0, '0, '0, 0, -1, '0);
        chk("b2b_resp_count", 32'(dut_resp_cnt - s), 32'd2);
        idle_cycles(1);

        repeat (150) random_txn();

        // Reset pulsed during WAIT, then stray rvalid afterwards.
        chk_en = 1'b0;
        mem_read = 1'b1;
        mem_write = 1'b0;
        mem_address = 32'h0000_3008;
        pmem_gnt = 1'b0;
        pmem_rvalid = 1'b0;
        @(negedge clk);
        chk("rsw_req", 32'(pmem_req), 32'h1);
        pmem_gnt = 1'b1;
        @(negedge clk);
        pmem_gnt = 1'b0;
        chk("rsw_wait_req", 32'(pmem_req), 32'h0);
        do_reset();
        s = dut_resp_cnt;
        for (int i = 0; i < 3; i++) begin
            pmem_rvalid = 1'b1;
            pmem_rdata = $urandom;
            @(negedge clk);
        end
        pmem_rvalid = 1'b0;
        chk("rsw_no_resp", 32'(dut_resp_cnt - s), 32'd0);

        // Grant never arrives: eight REQ cycles, then abort with err=2.
        s = dut_resp_cnt;
        txn(1'b0, 32'h0000_4002, 4'hF, 32'h0, 20, 0, 32'h0, 0,
            1'b1, 32'h0000_4000, 4'b0000, 8, -1, '0);
        chk("to_err", 32'(err), 32'd2);
        chk("to_no_resp", 32'(dut_resp_cnt - s), 32'd0);
        idle_cycles(2);

        // Collision sets err=1; a later timeout leaves it alone.
        do_reset();
        collide();
        chk("rw_err", 32'(err), 32'd1);
        chk("rw_no_req", 32'(pmem_req), 32'h0);
        txn(1'b1, 32'h0000_5000, 4'hF, 32'h1, 20, 0, 32'h0, 0,
            1'b0, '0, '0, 0, -1, '0);
        chk("rw_err_after_timeout", 32'(err), 32'd1);

        do_reset();
        repeat (60) begin
            if ($urandom_range(0, 5) == 0) collide();
            else random_txn();
        end
        idle_cycles(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_bridge.md
MEM_REQ_BRIDGE -- requirements
Module: mem_req_bridge

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, max cycles a transaction may spend in REQ+WAIT before abort.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_read  input  1  core read request, held until mem_resp.
REQ-005 mem_write  input  1  core write request, held until mem_resp.
REQ-006 mem_byte_enable  input  4  core write byte mask.
REQ-007 mem_address  input  32  core byte address.
REQ-008 mem_wdata  input  32  core write data.
REQ-009 mem_resp  output  1  one-cycle completion pulse to core.
REQ-010 mem_rdata  output  32  read data, valid while mem_resp=1.
REQ-011 pmem_req  output  1  request to pipelined memory.
REQ-012 pmem_we  output  1  1=write, 0=read.
REQ-013 pmem_addr  output  32  word-aligned address.
REQ-014 pmem_wmask  output  4  byte mask, 4'b0000 on reads.
REQ-015 pmem_wdata  output  32  write data.
REQ-016 pmem_gnt  input  1  memory accepts pmem_req this cycle.
REQ-017 pmem_rvalid  input  1  read data / write ack, one cycle, after gnt.
REQ-018 pmem_rdata  input  32  memory read data, valid with pmem_rvalid.
REQ-019 err  output  2  sticky error: 0 none, 1 read+write collision, 2 timeout.

Function
REQ-020 FSM states IDLE, REQ, WAIT, RESP; Moore outputs from registered state.
REQ-021 IDLE: exactly one of mem_read/mem_write high -> latch address, byte_enable, wdata, direction; next REQ.
REQ-022 IDLE: both high -> no request, err<=1 (unless err already nonzero), stay IDLE.
REQ-023 REQ: pmem_req=1, address/mask/data from latches; pmem_gnt=1 -> WAIT, else stay.
REQ-024 WAIT: pmem_rvalid=1 -> capture pmem_rdata (reads only), next RESP.
REQ-025 RESP: mem_resp=1 exactly one cycle, mem_rdata=captured data; next IDLE unconditionally.
REQ-026 Minimum latency: request sampled at edge N, gnt in cycle N+1, rvalid in N+2 -> mem_resp in cycle N+3.
REQ-027 pmem_addr = {latched_address[31:2], 2'b00}; pmem_wmask = latched byte_enable on writes, 4'b0000 on reads.
REQ-028 Core input changes after latching ignored until return to IDLE.
REQ-029 pmem_rvalid outside WAIT and pmem_gnt outside REQ ignored, no state change.
REQ-030 Watchdog counts cycles in REQ+WAIT, clears on IDLE entry; reaching TIMEOUT_CYCLES -> IDLE, no mem_resp, err<=2 if err==0.
REQ-031 err sticky: first nonzero code held until reset.
REQ-032 mem_rdata holds last captured value outside RESP; after a write, mem_rdata unchanged.

Reset
REQ-033 rst asserted at any time -> state IDLE, mem_resp=0, pmem_req=0, pmem_we=0, pmem_addr=0, pmem_wmask=0, pmem_wdata=0, mem_rdata=0, err=0, watchdog=0, immediately (asynchronous).
REQ-034 Transaction in flight at reset abandoned; a later stray pmem_rvalid in IDLE ignored.

Structure
REQ-035 Package mem_bridge_pkg holds state enum and err code enum (ERR_NONE, ERR_RW, ERR_TIMEOUT).
REQ-036 Watchdog counter sub-module bridge_watchdog (clear, enable, width $clog2(TIMEOUT_CYCLES+1), expired output).

Verification
REQ-037 Read 0x0000_1006, gnt next cycle, rvalid with 0xDEAD_BEEF one later -> pmem_addr 0x0000_1004, mask 0000, mem_resp one cycle with 0xDEAD_BEEF at cycle N+3.
REQ-038 Write 0x0000_2000, be 4'b0011, wdata 0x1234_5678, gnt delayed 5 cycles -> pmem_req held 6 cycles, pmem_we=1, mask 0011, mem_resp once after rvalid.
REQ-039 mem_read=mem_write=1 in IDLE -> no pmem_req, err=1; later timeout does not change err.
REQ-040 TIMEOUT_CYCLES=8, gnt never asserted -> IDLE after 8 cycles in REQ, err=2, no mem_resp.
REQ-041 rst pulsed during WAIT, rvalid arrives afterward -> all outputs zero, state IDLE, no mem_resp.
REQ-042 Back-to-back read then write, core requests immediately after each mem_resp -> two distinct transactions, exactly two mem_resp pulses, no reissue.
